// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and an optional iterative shift-add multiplier.
// Latency: 1 edge for single-cycle ops; MUL raises out_valid WIDTH+1 edges after the accept edge.
// Backpressure: result and flags are held in DONE until out_ready; in_ready is high only in IDLE.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = SHW + 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_PASSA = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_y;
  logic               r_zero;
  logic               r_neg;
  logic               r_carry;
  logic               r_ovf;
  logic               r_illegal;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_illegal;
  logic               w_is_mul;
  logic               w_mul_last;

  assign w_sh       = data_b[SHW-1:0];
  assign w_sum      = {1'b0, data_a} + {1'b0, data_b};
  assign w_dif      = {1'b0, data_a} - {1'b0, data_b};
  assign w_is_mul   = (op == OP_MUL) && (MUL_EN != 0);
  // The counter reaches WIDTH after the last add/shift step; that cycle only publishes acc.
  assign w_mul_last = (r_cnt == CNT_W'(WIDTH));

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign y         = r_y;
  assign zero      = r_zero;
  assign negative  = r_neg;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign illegal   = r_illegal;

  // Single-cycle result and carry/overflow/illegal for the presented opcode.
  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (data_a[MSB] == data_b[MSB]) && (w_sum[MSB] != data_a[MSB]);
      end
      OP_SUB: begin
        w_res   = w_dif[WIDTH-1:0];
        w_carry = ~w_dif[WIDTH];  // no borrow means a >= b
        w_ovf   = (data_a[MSB] != data_b[MSB]) && (w_dif[MSB] != data_a[MSB]);
      end
      OP_AND:   w_res = data_a & data_b;
      OP_OR:    w_res = data_a | data_b;
      OP_XOR:   w_res = data_a ^ data_b;
      OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(data_a) < $signed(data_b))};
      OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (data_a < data_b)};
      OP_SLL:   w_res = data_a << w_sh;
      OP_SRL:   w_res = data_a >> w_sh;
      OP_SRA:   w_res = $unsigned($signed(data_a) >>> w_sh);
      OP_PASSA: w_res = data_a;
      OP_MUL:   w_illegal = (MUL_EN == 0);  // with the multiplier built this path is never captured
      default:  w_illegal = 1'b1;
    endcase
  end

  // Next-state logic: accept only in IDLE, iterate in BUSY, hold in DONE until consumed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
      S_BUSY: if (w_mul_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Result/flag registers and the shift-add multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_is_mul) begin
              r_mcand  <= data_a;
              r_mplier <= data_b;
              r_acc    <= '0;
              r_cnt    <= '0;
            end else begin
              r_y       <= w_res;
              r_zero    <= (w_res == '0);
              r_neg     <= w_res[MSB];
              r_carry   <= w_carry;
              r_ovf     <= w_ovf;
              r_illegal <= w_illegal;
            end
          end
        end
        S_BUSY: begin
          if (w_mul_last) begin
            r_y       <= r_acc;
            r_zero    <= (r_acc == '0);
            r_neg     <= r_acc[MSB];
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, hand-written multi-cycle sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_alu_seq;

  localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND_ = 4'd2, OR_ = 4'd3;
  localparam logic [3:0] XOR_ = 4'd4, SLT = 4'd5,  SLTU = 4'd6, SLL = 4'd7;
  localparam logic [3:0] SRL = 4'd8,  SRA = 4'd9,  PASSA = 4'd10, MUL = 4'd11;

  typedef struct packed {
    logic [31:0] y;
    logic z, n, c, v, il;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    res_t        exp;
  } vec_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] data_a, data_b, y;
  logic        zero, negative, carry, overflow, illegal;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0]  op1;
  logic [31:0] data_a1, data_b1, y1;
  logic        zero1, negative1, carry1, overflow1, illegal1;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.WIDTH(32), .MUL_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_a(data_a), .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .illegal(illegal)
  );

  alu_seq #(.WIDTH(32), .MUL_EN(0)) u_dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .op(op1),
    .data_a(data_a1), .data_b(data_b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .y(y1), .zero(zero1), .negative(negative1), .carry(carry1), .overflow(overflow1),
    .illegal(illegal1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic res_t dut_res();
    res_t r;
    r.y = y; r.z = zero; r.n = negative; r.c = carry; r.v = overflow; r.il = illegal;
    return r;
  endfunction

  // Reference model: true mathematical results, then reduced to 32 bits.
  function automatic res_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t            r;
    longint unsigned ua, ub;
    longint          sa, sb, s;
    int              sh;
    r  = '0;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (o)
      ADD: begin
        s = sa + sb; r.y = 32'(ua + ub);
        r.c = (ua + ub) > 64'hFFFF_FFFF;
        r.v = (s != longint'($signed(r.y)));
      end
      SUB: begin
        s = sa - sb; r.y = 32'(ua - ub);
        r.c = (ua >= ub);
        r.v = (s != longint'($signed(r.y)));
      end
      AND_:  r.y = a & b;
      OR_:   r.y = a | b;
      XOR_:  r.y = a ^ b;
      SLT:   r.y = (sa < sb) ? 32'd1 : 32'd0;
      SLTU:  r.y = (ua < ub) ? 32'd1 : 32'd0;
      SLL:   r.y = 32'(ua << sh);
      SRL:   r.y = 32'(ua >> sh);
      SRA:   r.y = 32'(sa >>> sh);
      PASSA: r.y = a;
      MUL:   r.y = 32'(ua * ub);
      default: r.il = 1'b1;
    endcase
    r.z = (r.y == 32'd0);
    r.n = r.y[31];
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] yv, input logic z, input logic n,
                              input logic c, input logic v, input logic il);
    vec_t t;
    t.op = o; t.a = a; t.b = b;
    t.exp.y = yv; t.exp.z = z; t.exp.n = n; t.exp.c = c; t.exp.v = v; t.exp.il = il;
    return t;
  endfunction

  // Present one op to the MUL_EN=1 instance, optionally stall the consumer, then hand off.
  // Latency counts edges from presentation: the accept edge itself for single-cycle ops,
  // the accept edge plus WIDTH+1 more for MUL.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output res_t r);
    int lat;
    @(negedge clk);
    out_ready = (stall == 0);
    op = o; data_a = a; data_b = b; in_valid = 1'b1;
    lat = 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op%0d", o), 64'(lat), (o == MUL) ? 64'd34 : 64'd1);
    r = dut_res();
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("stall_hold", 64'({out_valid, in_ready, dut_res()}), 64'({2'b10, r}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff", 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    vec_t  tbl[18];
    res_t  r, e;
    int    seen;
    logic [31:0] ra, rb;
    logic [3:0]  ro;

    tbl[0]  = mk(ADD,   32'hFFFF_FFFF, 32'h1,          32'h0,          1, 0, 1, 0, 0);
    tbl[1]  = mk(ADD,   32'h7FFF_FFFF, 32'h1,          32'h8000_0000,  0, 1, 0, 1, 0);
    tbl[2]  = mk(SUB,   32'd3,         32'd5,          32'hFFFF_FFFE,  0, 1, 0, 0, 0);
    tbl[3]  = mk(SLT,   32'hFFFF_FFFF, 32'h1,          32'h1,          0, 0, 0, 0, 0);
    tbl[4]  = mk(SLTU,  32'hFFFF_FFFF, 32'h1,          32'h0,          1, 0, 0, 0, 0);
    tbl[5]  = mk(SRA,   32'h8000_0000, 32'h24,         32'hF800_0000,  0, 1, 0, 0, 0);
    tbl[6]  = mk(SRL,   32'h8000_0000, 32'h24,         32'h0800_0000,  0, 0, 0, 0, 0);
    tbl[7]  = mk(SLL,   32'h1234_5678, 32'h20,         32'h1234_5678,  0, 0, 0, 0, 0);
    tbl[8]  = mk(4'd13, 32'h1234_5678, 32'h9,          32'h0,          1, 0, 0, 0, 1);
    tbl[9]  = mk(SUB,   32'd5,         32'd5,          32'h0,          1, 0, 1, 0, 0);
    tbl[10] = mk(SUB,   32'h8000_0000, 32'h1,          32'h7FFF_FFFF,  0, 0, 1, 1, 0);
    tbl[11] = mk(AND_,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000,  0, 1, 0, 0, 0);
    tbl[12] = mk(OR_,   32'h0F0F_0000, 32'h0000_00F0,  32'h0F0F_00F0,  0, 0, 0, 0, 0);
    tbl[13] = mk(XOR_,  32'hFFFF_FFFF, 32'h0F0F_0F0F,  32'hF0F0_F0F0,  0, 1, 0, 0, 0);
    tbl[14] = mk(PASSA, 32'h8000_0001, 32'hDEAD_BEEF,  32'h8000_0001,  0, 1, 0, 0, 0);
    tbl[15] = mk(SLL,   32'h1,         32'h1F,         32'h8000_0000,  0, 1, 0, 0, 0);
    tbl[16] = mk(SRL,   32'h8000_0000, 32'hFFFF_FFE1,  32'h4000_0000,  0, 0, 0, 0, 0);
    tbl[17] = mk(4'd15, 32'h0,         32'h0,          32'h0,          1, 0, 0, 0, 1);

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; data_a = '0; data_b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; op1 = '0; data_a1 = '0; data_b1 = '0;
    #2 rst_n = 1'b0;
    #2;
    check("reset_state", 64'({out_valid, in_ready, dut_res()}), 64'({2'b01, 37'b0}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 18; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, r);
      check($sformatf("vec%0d", i), 64'(r), 64'(tbl[i].exp));
    end

    // MUL: busy window, ignored in_valid pulses, exact completion edge.
    @(negedge clk);
    op = MUL; data_a = 32'h0001_0003; data_b = 32'h0002_0005; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 33; i++) begin
      op = ADD; data_a = $urandom; data_b = $urandom; in_valid = i[0];
      @(posedge clk); #1;
      check($sformatf("mul_cycle%0d", i), 64'({in_ready, out_valid}), 64'({1'b0, (i == 33)}));
    end
    in_valid = 1'b0;
    check("mul_result", 64'(dut_res()), 64'({32'h000B_000F, 5'b00000}));
    @(posedge clk); #1;
    check("mul_handoff", 64'({out_valid, in_ready}), 64'(2'b01));
    @(posedge clk); #1;
    check("mul_no_ghost", 64'(out_valid), 64'd0);

    // Long backpressure on a single-cycle op and on a MUL.
    do_op(ADD, 32'h7FFF_FFFF, 32'h1, 10, r);
    check("bp_add", 64'(r), 64'(model(ADD, 32'h7FFF_FFFF, 32'h1)));
    do_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, r);
    check("bp_mul", 64'(r), 64'({32'h1, 5'b00000}));

    // MUL disabled build: op 11 is illegal with single-cycle latency.
    @(negedge clk);
    op1 = MUL; data_a1 = 32'h0000_0007; data_b1 = 32'h0000_0009; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("nomul_illegal",
          64'({out_valid1, y1, zero1, negative1, carry1, overflow1, illegal1}),
          64'({1'b1, 32'h0, 5'b10001}));
    @(posedge clk); #1;
    check("nomul_handoff", 64'({out_valid1, in_ready1}), 64'(2'b01));

    // Asynchronous reset in the middle of a MUL.
    @(negedge clk);
    op = MUL; data_a = 32'h1234_5678; data_b = 32'h0000_0003; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async", 64'({out_valid, in_ready, dut_res()}), 64'({2'b01, 37'b0}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    check("no_stale_result", 64'(seen), 64'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'h7FFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'hFFFF_FFFF;
        1: rb = 32'($urandom_range(0, 40));
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, $urandom_range(0, 2), r);
      e = model(ro, ra, rb);
      check($sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb), 64'(r), 64'(e));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
